// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: requests a word at pc, hands it to decode,
// then steps pc (sequential, jump or taken branch). A memory timeout is sticky.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   mem_dir, mem_leer    : instruction memory address / read request
//   mem_dato, mem_listo  : memory read data / data valid
//   instruccion          : fetched word to decode
//   instr_valida         : instruccion holds a valid word
//   instr_tomada         : decode accepts instruccion this cycle
//   Salto, dir_salto     : unconditional jump and its 26-bit target
//   SaltoCond, Zero      : conditional branch, taken when Zero is set
//   desplazamiento       : sign-extended branch offset in words
//   pc_actual, pc_mas4   : pc of instruccion, and pc + 4
//   error_mem            : sticky memory-timeout flag
module unidad_busqueda #(
  parameter logic [31:0] PC_INICIO     = 32'h0000_0000,
  parameter int          LIMITE_ESPERA = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_dir,
  output logic        mem_leer,
  input  logic [31:0] mem_dato,
  input  logic        mem_listo,
  output logic [31:0] instruccion,
  output logic        instr_valida,
  input  logic        instr_tomada,
  input  logic        Salto,
  input  logic [25:0] dir_salto,
  input  logic        SaltoCond,
  input  logic        Zero,
  input  logic [31:0] desplazamiento,
  output logic [31:0] pc_actual,
  output logic [31:0] pc_mas4,
  output logic        error_mem
);

  localparam int W = $clog2(LIMITE_ESPERA + 1);

  typedef enum logic [1:0] {
    BUSCA   = 2'd0,
    ENTREGA = 2'd1,
    ERROR   = 2'd2
  } estado_t;

  estado_t        r_estado;
  estado_t        w_estado_sig;
  logic [31:0]    r_pc;
  logic [31:0]    r_instr;
  logic [W-1:0]   r_espera;
  logic           r_error;

  logic [31:0]    w_pc_mas4;
  logic [31:0]    w_pc_sig;
  logic [W-1:0]   w_espera_sig;
  logic           w_timeout;

  assign w_pc_mas4    = r_pc + 32'd4;
  assign w_espera_sig = r_espera + W'(1);
  // The miss in this cycle is the one that exhausts the budget.
  assign w_timeout    = !mem_listo &&
                        (w_espera_sig == W'(LIMITE_ESPERA));

  always_comb begin
    w_pc_sig = w_pc_mas4;
    if (Salto)
      w_pc_sig = {w_pc_mas4[31:28], dir_salto, 2'b00};
    else if (SaltoCond && Zero)
      w_pc_sig = w_pc_mas4 + (desplazamiento << 2);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_estado <= BUSCA;
    else
      r_estado <= w_estado_sig;
  end

  // Next-state logic
  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      BUSCA: begin
        if (mem_listo)
          w_estado_sig = ENTREGA;
        else if (w_timeout)
          w_estado_sig = ERROR;
      end
      ENTREGA: begin
        if (instr_tomada)
          w_estado_sig = BUSCA;
      end
      ERROR:   w_estado_sig = ERROR;
      default: w_estado_sig = BUSCA;
    endcase
  end

  // Outputs; the read request is gated so nothing is issued while in reset.
  always_comb begin
    mem_leer     = (r_estado == BUSCA) && !reset;
    instr_valida = (r_estado == ENTREGA);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= PC_INICIO;
      r_instr  <= 32'd0;
      r_espera <= '0;
      r_error  <= 1'b0;
    end else begin
      unique case (r_estado)
        BUSCA: begin
          if (mem_listo) begin
            r_instr  <= mem_dato;
            r_espera <= '0;
          end else begin
            r_espera <= w_espera_sig;
            if (w_timeout)
              r_error <= 1'b1;
          end
        end
        ENTREGA: begin
          if (instr_tomada)
            r_pc <= w_pc_sig;
        end
        default: ;
      endcase
    end
  end

  assign mem_dir     = r_pc;
  assign pc_actual   = r_pc;
  assign pc_mas4     = w_pc_mas4;
  assign instruccion = r_instr;
  assign error_mem   = r_error;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for unidad_busqueda: fetch/accept, branches, jumps,
// wrap-around, stall hold, timeout and reset recovery.
module tb_unidad_busqueda;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_dir;
  logic        mem_leer;
  logic [31:0] mem_dato;
  logic        mem_listo;
  logic [31:0] instruccion;
  logic        instr_valida;
  logic        instr_tomada;
  logic        Salto;
  logic [25:0] dir_salto;
  logic        SaltoCond;
  logic        Zero;
  logic [31:0] desplazamiento;
  logic [31:0] pc_actual;
  logic [31:0] pc_mas4;
  logic        error_mem;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unidad_busqueda dut (
    .clk            (clk),
    .reset          (reset),
    .mem_dir        (mem_dir),
    .mem_leer       (mem_leer),
    .mem_dato       (mem_dato),
    .mem_listo      (mem_listo),
    .instruccion    (instruccion),
    .instr_valida   (instr_valida),
    .instr_tomada   (instr_tomada),
    .Salto          (Salto),
    .dir_salto      (dir_salto),
    .SaltoCond      (SaltoCond),
    .Zero           (Zero),
    .desplazamiento (desplazamiento),
    .pc_actual      (pc_actual),
    .pc_mas4        (pc_mas4),
    .error_mem      (error_mem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic br(input logic s, input logic [25:0] d,
                    input logic sc, input logic z,
                    input logic [31:0] ds);
    Salto = s; dir_salto = d; SaltoCond = sc;
    Zero = z; desplazamiento = ds;
  endtask

  // BUSCA -> ENTREGA with word w, no accept during the fetch
  task automatic fetch(input logic [31:0] w);
    instr_tomada = 1'b0;
    mem_listo = 1'b1;
    mem_dato  = w;
    tick();
    mem_listo = 1'b0;
  endtask

  // Accept in ENTREGA with the branch inputs currently driven
  task automatic accept();
    instr_tomada = 1'b1;
    tick();
    instr_tomada = 1'b0;
    br(1'b0, 26'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    mem_dato = 32'hDEAD_BEEF;
    mem_listo = 1'b1;
    instr_tomada = 1'b1;
    br(1'b1, 26'h3FF_FFFF, 1'b1, 1'b1, 32'h1);
    tick();
    tick();
    chk("rst_leer", {31'd0, mem_leer}, 32'd0);
    chk("rst_dir", mem_dir, 32'h0);
    chk("rst_valida", {31'd0, instr_valida}, 32'd0);
    chk("rst_err", {31'd0, error_mem}, 32'd0);
    chk("rst_instr", instruccion, 32'd0);

    // First fetch after reset
    reset = 1'b0;
    br(1'b0, 26'd0, 1'b0, 1'b0, 32'd0);
    instr_tomada = 1'b0;
    mem_listo = 1'b1;
    mem_dato = 32'h2008_0005;
    #1;
    chk("f0_leer", {31'd0, mem_leer}, 32'd1);
    chk("f0_dir", mem_dir, 32'h0);
    tick();
    mem_listo = 1'b0;
    chk("f0_instr", instruccion, 32'h2008_0005);
    chk("f0_valida", {31'd0, instr_valida}, 32'd1);
    chk("f0_leer_ent", {31'd0, mem_leer}, 32'd0);
    chk("f0_pc", pc_actual, 32'h0);
    chk("f0_pc4", pc_mas4, 32'h4);
    accept();
    chk("f0_next", mem_dir, 32'h4);
    chk("f0_busca", {31'd0, instr_valida}, 32'd0);

    // Taken branch backwards from pc=8
    fetch(32'h1111_1111);
    accept();
    chk("seq_8", mem_dir, 32'h8);
    fetch(32'h2222_2222);
    br(1'b0, 26'd0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    accept();
    chk("beq_taken", mem_dir, 32'h4);

    // Same branch not taken
    fetch(32'h1111_1111);
    accept();
    fetch(32'h2222_2222);
    br(1'b0, 26'd0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    accept();
    chk("beq_not", mem_dir, 32'hC);

    // Stall in ENTREGA at pc=12; noise on memory and branch inputs
    fetch(32'hAAAA_5555);
    for (int i = 0; i < 5; i++) begin
      mem_listo = i[0];
      mem_dato = 32'h0BAD_0000 + i;
      br(1'b1, 26'h155_5555, 1'b1, 1'b1, 32'h7);
      tick();
      chk("hold_instr", instruccion, 32'hAAAA_5555);
      chk("hold_pc", pc_actual, 32'hC);
      chk("hold_valida", {31'd0, instr_valida}, 32'd1);
      chk("hold_leer", {31'd0, mem_leer}, 32'd0);
    end
    mem_listo = 1'b0;

    // Branch up to 0x1000_0010
    br(1'b0, 26'd0, 1'b1, 1'b1, 32'h0400_0000);
    accept();
    chk("br_far", mem_dir, 32'h1000_0010);

    // Jump beats branch
    fetch(32'h0800_0040);
    br(1'b1, 26'h000_0040, 1'b1, 1'b1, 32'h0000_0100);
    accept();
    chk("jmp_wins", mem_dir, 32'h1000_0100);

    // Branch to the top word, then wrap to 0
    fetch(32'h3333_3333);
    br(1'b0, 26'd0, 1'b1, 1'b1, 32'h3BFF_FFBE);
    accept();
    chk("br_top", mem_dir, 32'hFFFF_FFFC);
    fetch(32'h4444_4444);
    chk("wrap_pc4", pc_mas4, 32'h0);
    accept();
    chk("wrap_dir", mem_dir, 32'h0);

    // Jump to 0x40, then reset mid-wait
    fetch(32'h5555_5555);
    br(1'b0, 26'h000_0010, 1'b0, 1'b0, 32'd0);
    Salto = 1'b1;
    accept();
    chk("jmp_40", mem_dir, 32'h40);
    for (int i = 0; i < 5; i++) tick();
    chk("wait_leer", {31'd0, mem_leer}, 32'd1);
    chk("wait_dir", mem_dir, 32'h40);
    reset = 1'b1;
    mem_listo = 1'b1;
    instr_tomada = 1'b1;
    #1;
    chk("rstw_leer", {31'd0, mem_leer}, 32'd0);
    tick();
    reset = 1'b0;
    mem_listo = 1'b0;
    instr_tomada = 1'b0;
    #1;
    chk("rstw_dir", mem_dir, 32'h0);
    chk("rstw_leer2", {31'd0, mem_leer}, 32'd1);

    // Timeout: 15 misses survive, 16th trips error
    for (int i = 0; i < 15; i++) tick();
    chk("to15_err", {31'd0, error_mem}, 32'd0);
    chk("to15_leer", {31'd0, mem_leer}, 32'd1);
    tick();
    chk("to16_err", {31'd0, error_mem}, 32'd1);
    chk("to16_leer", {31'd0, mem_leer}, 32'd0);

    // ERROR absorbs everything but reset
    mem_listo = 1'b1;
    instr_tomada = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_flag", {31'd0, error_mem}, 32'd1);
      chk("err_leer", {31'd0, mem_leer}, 32'd0);
      chk("err_valida", {31'd0, instr_valida}, 32'd0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_listo = 1'b0;
    instr_tomada = 1'b0;
    #1;
    chk("rec_err", {31'd0, error_mem}, 32'd0);
    chk("rec_dir", mem_dir, 32'h0);
    chk("rec_leer", {31'd0, mem_leer}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/unidad_busqueda.md
UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

Interface
REQ-001 SHALL have parameter PC_INICIO, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter LIMITE_ESPERA, default 16: maximum BUSCA cycles without mem_listo before error.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port mem_dir, output, 32: instruction memory address (registered PC).
REQ-006 SHALL have port mem_leer, output, 1: instruction memory read request.
REQ-007 SHALL have port mem_dato, input, 32: instruction word from memory.
REQ-008 SHALL have port mem_listo, input, 1: memory data valid for the current request.
REQ-009 SHALL have port instruccion, output, 32: fetched instruction word to the control/decode stage.
REQ-010 SHALL have port instr_valida, output, 1: instruccion holds a valid word.
REQ-011 SHALL have port instr_tomada, input, 1: downstream accepts instruccion this cycle.
REQ-012 SHALL have port Salto, input, 1: unconditional jump for the instruction being accepted.
REQ-013 SHALL have port dir_salto, input, 26: jump target field.
REQ-014 SHALL have port SaltoCond, input, 1: conditional branch for the instruction being accepted.
REQ-015 SHALL have port Zero, input, 1: ALU zero flag qualifying SaltoCond.
REQ-016 SHALL have port desplazamiento, input, 32: sign-extended branch offset in words.
REQ-017 SHALL have port pc_actual, output, 32: PC of the word in instruccion.
REQ-018 SHALL have port pc_mas4, output, 32: pc_actual + 4, modulo 2^32.
REQ-019 SHALL have port error_mem, output, 1: sticky memory-timeout flag.

Function
REQ-020 SHALL implement an FSM with states BUSCA, ENTREGA and ERROR.
REQ-021 In BUSCA: mem_leer=1, mem_dir=pc, instr_valida=0; mem_dir SHALL stay stable until mem_listo is sampled high.
REQ-022 In BUSCA, when mem_listo=1: mem_dato SHALL be registered into instruccion, the wait counter cleared, and the next state SHALL be ENTREGA (one cycle after mem_listo).
REQ-023 In ENTREGA: mem_leer=0, instr_valida=1; instruccion and pc_actual SHALL be held unchanged until instr_tomada=1.
REQ-024 In ENTREGA with instr_tomada=1: pc SHALL be loaded with the next PC and the next state SHALL be BUSCA.
REQ-025 Next-PC priority: Salto=1 gives {pc_mas4[31:28], dir_salto, 2'b00}; otherwise SaltoCond=1 and Zero=1 gives pc_mas4 + (desplazamiento<<2); otherwise pc_mas4.
REQ-026 All PC arithmetic SHALL be 32-bit with silent wrap-around (e.g. 32'hFFFF_FFFC + 4 = 0).
REQ-027 Salto, dir_salto, SaltoCond, Zero and desplazamiento SHALL be sampled only in the ENTREGA cycle where instr_tomada=1, and ignored otherwise.
REQ-028 mem_listo outside BUSCA and instr_tomada outside ENTREGA SHALL be ignored.
REQ-029 The wait counter SHALL increment on each BUSCA cycle with mem_listo=0.
REQ-030 When the wait counter reaches LIMITE_ESPERA: error_mem SHALL be set, the next state SHALL be ERROR, and mem_leer SHALL fall the following cycle.
REQ-031 ERROR SHALL be absorbing until reset: mem_leer=0, instr_valida=0, error_mem=1.
REQ-032 Throughput: one instruction per 2 cycles minimum (BUSCA with mem_listo=1, then ENTREGA with instr_tomada=1).

Reset
REQ-033 On reset=1 at a clock edge, regardless of state, the block SHALL set: pc=PC_INICIO, state=BUSCA, instruccion=0, instr_valida=0, error_mem=0, wait counter=0.
REQ-034 During reset, mem_leer SHALL be 0, and mem_listo, instr_tomada and the branch inputs SHALL be ignored.
REQ-035 Any read outstanding when reset is applied SHALL be abandoned; the first cycle after reset deasserts SHALL request address PC_INICIO.

Verification
REQ-036 Reset release, mem_listo=1 returning 32'h2008_0005, instr_tomada=1 -> mem_dir=0, then instruccion=32'h2008_0005 with instr_valida=1, then mem_dir=4.
REQ-037 Accept at pc=8 with SaltoCond=1, Zero=1, desplazamiento=32'hFFFF_FFFE -> next mem_dir=4; the same stimulus with Zero=0 -> next mem_dir=12.
REQ-038 Accept at pc=32'h1000_0010 with Salto=1, SaltoCond=1, Zero=1, dir_salto=26'h000_0040 -> next mem_dir=32'h1000_0100 (jump wins).
REQ-039 Hold instr_tomada=0 for 5 cycles in ENTREGA while toggling mem_listo/mem_dato -> instruccion, pc_actual and instr_valida unchanged, mem_leer=0.
REQ-040 Keep mem_listo=0 for 16 BUSCA cycles -> error_mem=1, mem_leer=0 from then on; then reset=1 for one cycle -> error_mem=0, mem_dir=PC_INICIO.
REQ-041 Assert reset in BUSCA mid-wait at pc=32'h40 -> mem_leer=0 during reset, then mem_dir=PC_INICIO with the wait counter restarted.
